// File: rtl/enc8to3_sequencer.sv
// ---------------------------------------------------------------------------
// enc8to3_sequencer
//
// Captures a set of active-low request lines into a pending mask, then emits
// the binary index of each pending request one at a time over a valid/ready
// handshake. The emission order is chosen by MSB_FIRST. After the last code
// is transferred, a one-cycle done pulse is raised before returning to idle.
//
// Parameters:
//   MSB_FIRST  1 = bit 7 emitted first (SN74148 order), 0 = bit 0 first
//
// Optional build macro:
//   ENC8TO3_CASCADE_EN  adds the SN74148-style cascade outputs gs_n / eo_n
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous active-high reset
//   ei_n       active-low enable, gates capture only
//   req_n      active-low request lines [7:0]
//   load       capture strobe
//   out_ready  consumer ready for enc_out
//   enc_out    binary code of the current request
//   out_valid  enc_out holds a valid code
//   busy       high whenever not idle
//   done       one-cycle pulse at the end of a burst
//   pending    requests not yet emitted, active-high
//   gs_n       (macro only) low while emitting
//   eo_n       (macro only) low when idle, enabled and no request present
// ---------------------------------------------------------------------------
module enc8to3_sequencer #(
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ei_n,
  input  logic [7:0] req_n,
  input  logic       load,
  input  logic       out_ready,
  output logic [2:0] enc_out,
  output logic       out_valid,
  output logic       busy,
  output logic       done,
`ifdef ENC8TO3_CASCADE_EN
  output logic       gs_n,
  output logic       eo_n,
`endif
  output logic [7:0] pending
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] pending_q, pending_d;
  logic [2:0] selIdx;

  // Highest-priority set bit of a mask. The loop runs from lowest to highest
  // priority so the last match wins; an empty mask yields 0.
  function automatic logic [2:0] pickIndex(input logic [7:0] bits);
    logic [2:0] idx;
    idx = 3'd0;
    if (MSB_FIRST) begin
      for (int i = 0; i < 8; i++)
        if (bits[i]) idx = i[2:0];
    end else begin
      for (int i = 7; i >= 0; i--)
        if (bits[i]) idx = i[2:0];
    end
    return idx;
  endfunction

  assign selIdx = pickIndex(pending_q);

  // State and pending mask register; reset wins over everything else.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      pending_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
    end
  end

  // Next-state logic. Capture only happens from IDLE, so load/ei_n/req_n are
  // ignored for the whole burst. A transfer clears the bit currently shown
  // on enc_out; when that empties the mask the burst ends via DONE.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    unique case (state_q)
      IDLE: begin
        if (load && !ei_n) begin
          pending_d = ~req_n;
          state_d   = (~req_n != 8'h00) ? EMIT : DONE;
        end
      end
      EMIT: begin
        if (out_ready) begin
          pending_d = pending_q & ~(8'b0000_0001 << selIdx);
          if (pending_d == 8'h00) state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d   = IDLE;
        pending_d = 8'h00;
      end
    endcase
  end

  // Outputs are decoded from the registered state; only eo_n also looks at
  // the live enable and request inputs.
  always_comb begin
    out_valid = (state_q == EMIT);
    enc_out   = (state_q == EMIT) ? selIdx : 3'b000;
    busy      = (state_q != IDLE);
    done      = (state_q == DONE);
    pending   = pending_q;
`ifdef ENC8TO3_CASCADE_EN
    gs_n      = (state_q != EMIT);
    eo_n      = !((state_q == IDLE) && !ei_n && (req_n == 8'hFF));
`endif
  end

endmodule
